serial_to_parallel_conv: RTL and testbench

// - Deserialiser. Collects single-bit samples, qualified by serial_valid,

---
 rtl/serial_to_parallel_pkg.sv | 14 +
 rtl/s2p_bit_counter.sv | 35 +++
 rtl/serial_to_parallel_conv.sv | 68 ++++++
 tb/tb_serial_to_parallel_conv.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/serial_to_parallel_pkg.sv
// Shared constants and helpers for the serial-to-parallel deserialiser.
package serial_to_parallel_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Bit-counter width for a given word width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    int unsigned cw;
    cw = $clog2(w);
    if (cw < 1) cw = 1;
    return cw;
  endfunction

endpackage : serial_to_parallel_pkg

// File: rtl/s2p_bit_counter.sv
// Modulo-WIDTH bit counter with enable; flags the final bit position of a word.
module s2p_bit_counter
  import serial_to_parallel_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic last_o
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Wrap is explicit so non-power-of-two widths count correctly.
  always_comb begin
    count_d = count_q;
    if (en_i) begin
      if (count_q == LAST) count_d = '0;
      else                 count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign last_o = (count_q == LAST);

endmodule : s2p_bit_counter

// File: rtl/serial_to_parallel_conv.sv
// Deserialiser: gathers LSB-first valid-qualified bits into words, one-cycle valid pulse per word.
module serial_to_parallel_conv
  import serial_to_parallel_pkg::*;
#(
  parameter int unsigned width = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_valid,
  input  logic             serial_data,
  output logic             parallel_valid,
  output logic [width-1:0] parallel_data
);

  // Handshake: a bit transfers on every posedge with serial_valid=1; there is
  // no ready. parallel_valid is a single-cycle strobe with no backpressure.

  // Only the upper width-1 shift bits are stored: the lowest bit would be
  // shifted out at the same edge the word completes, so it is never needed.
  logic [width-2:0] shreg_q;
  logic [width-2:0] shreg_d;
  logic [width-1:0] word;
  logic [width-1:0] pdata_q;
  logic [width-1:0] pdata_d;
  logic             pvalid_q;
  logic             pvalid_d;
  logic             last_bit;

  s2p_bit_counter #(
    .WIDTH (width)
  ) u_bit_counter (
    .clk    (clk),
    .rst    (rst),
    .en_i   (serial_valid),
    .last_o (last_bit)
  );

  assign word = {serial_data, shreg_q};

  always_comb begin
    shreg_d  = shreg_q;
    pdata_d  = pdata_q;
    pvalid_d = 1'b0;
    if (serial_valid) begin
      shreg_d = word[width-1:1];
      if (last_bit) begin
        pdata_d  = word;
        pvalid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q  <= '0;
      pdata_q  <= '0;
      pvalid_q <= 1'b0;
    end else begin
      shreg_q  <= shreg_d;
      pdata_q  <= pdata_d;
      pvalid_q <= pvalid_d;
    end
  end

  assign parallel_valid = pvalid_q;
  assign parallel_data  = pdata_q;

endmodule : serial_to_parallel_conv

// File: tb/tb_serial_to_parallel_conv.sv
// Scoreboard bench for serial_to_parallel_conv (width = 8).
module tb_serial_to_parallel_conv;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         serial_valid;
  logic         serial_data;
  logic         parallel_valid;
  logic [W-1:0] parallel_data;

  serial_to_parallel_conv #(.width(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .serial_valid   (serial_valid),
    .serial_data    (serial_data),
    .parallel_valid (parallel_valid),
    .parallel_data  (parallel_data)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           pulse_cyc_q[$];
  int           pulses_seen = 0;
  int           checks = 0;
  int           errors = 0;

  logic [W-1:0] acc;
  int           nacc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst && parallel_valid) begin
      pulses_seen++;
      pulse_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got 0x%0h expected no word (cycle %0d)", parallel_data, cyc);
      end else begin
        check("word", parallel_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- drivers ----------------
  // Leaves serial_valid high so consecutive calls stream back-to-back.
  task automatic send_bit(input logic b);
    serial_valid = 1'b1;
    serial_data  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    serial_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      serial_data = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) send_bit(w[i]);
  endtask

  // Bit-level model: every W accepted bits form one expected word, LSB-first.
  task automatic send_modeled_bit(input logic b);
    acc[nacc] = b;
    nacc++;
    if (nacc == W) begin
      exp_q.push_back(acc);
      nacc = 0;
    end
    send_bit(b);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int           base_pulses;
    logic [W-1:0] last_word;

    rst          = 1'b1;
    serial_valid = 1'b1;
    serial_data  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_valid", {31'd0, parallel_valid}, 32'd0);
    check("reset_data", {24'd0, parallel_data}, 32'd0);
    #1;
    rst = 1'b0;
    serial_valid = 1'b0;
    @(posedge clk);
    #1;

    // Alternating 1,0,1,0... -> 8'h55
    exp_q.push_back(8'h55);
    for (int i = 0; i < W; i++) send_bit(((i % 2) == 0) ? 1'b1 : 1'b0);
    idle(3);

    // Back-to-back words, pulses exactly W cycles apart
    pulse_cyc_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    send_word(8'hA5);
    send_word(8'h3C);
    idle(3);
    check("b2b_pulse_count", pulse_cyc_q.size(), 2);
    if (pulse_cyc_q.size() == 2)
      check("b2b_spacing", pulse_cyc_q[1] - pulse_cyc_q[0], W);

    // 800 bits with ~50% valid duty
    base_pulses = pulses_seen;
    nacc = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      send_modeled_bit(1'($urandom_range(0, 1)));
    end
    idle(3);
    check("random_pulse_count", pulses_seen - base_pulses, 100);
    check("random_queue_drained", exp_q.size(), 0);

    // Reset mid-word: the 5 stale bits must be discarded
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    serial_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    base_pulses = pulses_seen;
    exp_q.push_back(8'hF0);
    send_word(8'hF0);
    idle(2);
    check("rst_mid_pulse_count", pulses_seen - base_pulses, 1);

    // Idle hold: no pulse, data keeps last word
    last_word = 8'hF0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_valid", {31'd0, parallel_valid}, 32'd0);
      check("idle_hold", {24'd0, parallel_data}, {24'd0, last_word});
      @(posedge clk);
      #1;
    end

    idle(2);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_serial_to_parallel_conv
